// File: rtl/display_pkg.sv
// ============================================================================
// Module   : display_pkg
// Brief    : Shared types and defaults for the display adapter timing path.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package display_pkg;

  localparam int DEF_CW = 10;
  localparam int DEF_PW = 32;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Layout shared with DataPath; do not reorder fields.
  typedef struct packed {
    logic [DEF_CW-1:0] hb;
    logic [DEF_CW-1:0] vb;
    logic [DEF_CW-1:0] aip;
    logic [DEF_CW-1:0] ail;
  } cfg_t;

endpackage

`default_nettype wire

// File: rtl/raster_counter.sv
// ============================================================================
// Module   : raster_counter
// Brief    : Free-running x/y raster position counter with line/frame wrap.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module raster_counter
  import display_pkg::*;
#(
  parameter int CW = DEF_CW
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run_i,
  input  logic        clear_i,
  input  logic [CW:0] htot_i,
  input  logic [CW:0] vtot_i,
  output logic [CW:0] x_o,
  output logic [CW:0] y_o,
  output logic        line_wrap_o,
  output logic        frame_wrap_o
);

  logic [CW:0] x_q, x_d;
  logic [CW:0] y_q, y_d;

  assign line_wrap_o  = run_i && (x_q == (htot_i - 1'b1));
  assign frame_wrap_o = line_wrap_o && (y_q == (vtot_i - 1'b1));
  assign x_o          = x_q;
  assign y_o          = y_q;

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (clear_i) begin
      x_d = '0;
      y_d = '0;
    end else if (run_i) begin
      if (line_wrap_o) begin
        x_d = '0;
        y_d = frame_wrap_o ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/display_timing_gen.sv
// ============================================================================
// Module   : display_timing_gen
// Brief    : Raster timing generator (hsync/vsync/de/coords) and pixel pump.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module display_timing_gen
  import display_pkg::*;
#(
  parameter int CW   = DEF_CW,
  parameter int PW   = DEF_PW,
  parameter int HS_W = 2,
  parameter int VS_L = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic [CW-1:0] hb_cfg,
  input  logic [CW-1:0] vb_cfg,
  input  logic [CW-1:0] aip_cfg,
  input  logic [CW-1:0] ail_cfg,
  input  logic [PW-1:0] pix_data,
  input  logic          pix_valid,
  output logic          pix_ready,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [PW-1:0] rgb_out,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          frame_start,
  output logic          underflow
);

  localparam logic [CW:0] HS_LEN_MAX = (CW+1)'(HS_W);
  localparam logic [CW:0] VS_LEN_MAX = (CW+1)'(VS_L);

  state_e        state_q, state_d;
  cfg_t          shadow_q, shadow_d;

  logic          start_ok;
  logic          load_cfg;
  logic          cnt_run;
  logic          cnt_clear;
  logic          line_wrap;
  logic          frame_wrap;

  logic [CW:0]   x_cnt, y_cnt;
  logic [CW:0]   aip_w, ail_w, hb_w, vb_w;
  logic [CW:0]   htot, vtot;
  logic [CW:0]   hs_len, vs_len;

  logic          run;
  logic          active;
  logic          hs_dec, vs_dec, fs_dec;

  logic          hsync_q, vsync_q, de_q, fs_q, uf_q;
  logic          uf_d;
  logic [PW-1:0] rgb_q, rgb_d;

  assign start_ok = enable && (aip_cfg != '0) && (ail_cfg != '0);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_ok) state_d = RUN;
      RUN:     if (frame_wrap && !start_ok) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_run   = (state_q == RUN);
    cnt_clear = (state_q == IDLE);
    load_cfg  = start_ok && ((state_q == IDLE) || frame_wrap);
  end

  // Config is only sampled at frame boundaries so a frame is never torn.
  always_comb begin
    shadow_d = shadow_q;
    if (load_cfg) begin
      shadow_d = '{hb: hb_cfg, vb: vb_cfg, aip: aip_cfg, ail: ail_cfg};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shadow_q <= '0;
    end else begin
      shadow_q <= shadow_d;
    end
  end

  assign aip_w = {1'b0, shadow_q.aip};
  assign ail_w = {1'b0, shadow_q.ail};
  assign hb_w  = {1'b0, shadow_q.hb};
  assign vb_w  = {1'b0, shadow_q.vb};
  assign htot  = aip_w + hb_w;
  assign vtot  = ail_w + vb_w;

  raster_counter #(
    .CW (CW)
  ) u_raster_counter (
    .clk          (clk),
    .rst_n        (reset),
    .run_i        (cnt_run),
    .clear_i      (cnt_clear),
    .htot_i       (htot),
    .vtot_i       (vtot),
    .x_o          (x_cnt),
    .y_o          (y_cnt),
    .line_wrap_o  (line_wrap),
    .frame_wrap_o (frame_wrap)
  );

  // ---------------------------------------------------------------- decode
  assign run    = (state_q == RUN);
  assign hs_len = (hb_w < HS_LEN_MAX) ? hb_w : HS_LEN_MAX;
  assign vs_len = (vb_w < VS_LEN_MAX) ? vb_w : VS_LEN_MAX;
  assign active = run && (x_cnt < aip_w) && (y_cnt < ail_w);
  assign hs_dec = run && (x_cnt >= aip_w) && (x_cnt < (aip_w + hs_len));
  assign vs_dec = run && (y_cnt >= ail_w) && (y_cnt < (ail_w + vs_len));
  assign fs_dec = run && (x_cnt == '0) && (y_cnt == '0);

  assign pix_ready = active;

  assign rgb_d = (active && pix_valid) ? pix_data : '0;
  assign uf_d  = run && (uf_q || (active && !pix_valid));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hsync_q <= 1'b0;
      vsync_q <= 1'b0;
      de_q    <= 1'b0;
      fs_q    <= 1'b0;
      uf_q    <= 1'b0;
      rgb_q   <= '0;
    end else begin
      hsync_q <= hs_dec;
      vsync_q <= vs_dec;
      de_q    <= active;
      fs_q    <= fs_dec;
      uf_q    <= uf_d;
      rgb_q   <= rgb_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign frame_start = fs_q;
  assign underflow   = uf_q;
  assign rgb_out     = rgb_q;

  // Positions beyond the CW-bit range (large blanking) read as all-ones.
  assign x = x_cnt[CW] ? {CW{1'b1}} : x_cnt[CW-1:0];
  assign y = y_cnt[CW] ? {CW{1'b1}} : y_cnt[CW-1:0];

endmodule

`default_nettype wire

// File: tb/tb_display_timing_gen.sv
// ============================================================================
// Module   : tb_display_timing_gen
// Brief    : Self-checking bench for display_timing_gen (frame-index model).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_display_timing_gen;

  localparam int CW   = 10;
  localparam int PW   = 32;
  localparam int HS_W = 2;
  localparam int VS_L = 1;

  logic          clk       = 1'b0;
  logic          reset     = 1'b0;
  logic          enable    = 1'b0;
  logic [CW-1:0] hb_cfg    = 10'd2;
  logic [CW-1:0] vb_cfg    = 10'd1;
  logic [CW-1:0] aip_cfg   = 10'd4;
  logic [CW-1:0] ail_cfg   = 10'd3;
  logic [PW-1:0] pix_data  = 32'd1;
  logic          pix_valid = 1'b1;

  logic          pix_ready, hsync, vsync, de, frame_start, underflow;
  logic [PW-1:0] rgb_out;
  logic [CW-1:0] x, y;

  display_timing_gen #(
    .CW (CW), .PW (PW), .HS_W (HS_W), .VS_L (VS_L)
  ) dut (
    .clk (clk), .reset (reset), .enable (enable),
    .hb_cfg (hb_cfg), .vb_cfg (vb_cfg), .aip_cfg (aip_cfg), .ail_cfg (ail_cfg),
    .pix_data (pix_data), .pix_valid (pix_valid), .pix_ready (pix_ready),
    .hsync (hsync), .vsync (vsync), .de (de), .rgb_out (rgb_out),
    .x (x), .y (y), .frame_start (frame_start), .underflow (underflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit start_ok();
    return enable && (aip_cfg != 0) && (ail_cfg != 0);
  endfunction

  // Frame model: position is a linear index into the frame; x/y derive from it.
  bit            m_run = 0;
  int            m_p = 0, m_aip = 0, m_hb = 0, m_ail = 0, m_vb = 0;
  logic          e_hs = 0, e_vs = 0, e_de = 0, e_fs = 0, e_uf = 0;
  logic [PW-1:0] e_rgb = '0;

  always @(posedge clk) begin : model
    int ht, vt, hx, vy, ex, ey;
    bit act, erdy;
    if (!reset) begin
      m_run = 0; m_p = 0;
      e_hs = 0; e_vs = 0; e_de = 0; e_fs = 0; e_uf = 0; e_rgb = '0;
    end else begin
      ht  = m_aip + m_hb;
      vt  = m_ail + m_vb;
      hx  = (m_run && ht > 0) ? m_p % ht : 0;
      vy  = (m_run && ht > 0) ? m_p / ht : 0;
      act = m_run && hx < m_aip && vy < m_ail;
      e_de  = act;
      e_rgb = (act && pix_valid) ? pix_data : '0;
      e_hs  = m_run && hx >= m_aip && hx < m_aip + ((HS_W < m_hb) ? HS_W : m_hb);
      e_vs  = m_run && vy >= m_ail && vy < m_ail + ((VS_L < m_vb) ? VS_L : m_vb);
      e_fs  = m_run && m_p == 0;
      e_uf  = m_run && (e_uf || (act && !pix_valid));
      if (!m_run) begin
        if (start_ok()) begin
          m_run = 1; m_p = 0;
          m_aip = aip_cfg; m_hb = hb_cfg; m_ail = ail_cfg; m_vb = vb_cfg;
        end
      end else begin
        m_p++;
        if (m_p == ht * vt) begin
          m_p = 0;
          if (start_ok()) begin
            m_aip = aip_cfg; m_hb = hb_cfg; m_ail = ail_cfg; m_vb = vb_cfg;
          end else begin
            m_run = 0;
          end
        end
      end
    end
    #1;
    ht   = m_aip + m_hb;
    ex   = (m_run && ht > 0) ? m_p % ht : 0;
    ey   = (m_run && ht > 0) ? m_p / ht : 0;
    erdy = m_run && ex < m_aip && ey < m_ail;
    chk("cycle{x,y,rdy,hs,vs,de,fs,uf,rgb}",
        {x, y, pix_ready, hsync, vsync, de, frame_start, underflow, rgb_out},
        {CW'(ex), CW'(ey), erdy, e_hs, e_vs, e_de, e_fs, e_uf, e_rgb});
  end

  // Window statistics gathered by the stimulus stepper.
  int            cyc = 0;
  int            cnt_de, cnt_hs, cnt_vs, cnt_fs, cnt_rdy;
  int            fs_q[$];
  logic [PW-1:0] rgb_q[$];

  task automatic clr_stats();
    cnt_de = 0; cnt_hs = 0; cnt_vs = 0; cnt_fs = 0; cnt_rdy = 0;
    fs_q.delete(); rgb_q.delete();
  endtask

  // Advance one clock; pix_data counts up on every accepted pixel.
  task automatic step();
    logic acc;
    acc = pix_ready && pix_valid;
    @(posedge clk);
    #2;
    cyc++;
    if (acc) pix_data = pix_data + 1;
    if (de) begin cnt_de++; rgb_q.push_back(rgb_out); end
    if (hsync) cnt_hs++;
    if (vsync) cnt_vs++;
    if (pix_ready) cnt_rdy++;
    if (frame_start) begin cnt_fs++; fs_q.push_back(cyc); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int found;
    bit chg;
    clr_stats();
    @(posedge clk); #2;
    step(); step();
    chk("reset_state", {x, y, pix_ready, hsync, vsync, de, frame_start, underflow, rgb_out}, 64'd0);
    reset = 1'b1;
    step();
    chk("idle_no_ready", pix_ready, 1'b0);

    // Basic frame 4+2 x 3+1, two frames.
    clr_stats();
    enable = 1'b1;
    repeat (49) step();
    chk("basic_fs_count", cnt_fs, 2);
    chk("basic_fs_period", (fs_q.size() >= 2) ? fs_q[1] - fs_q[0] : -1, 24);
    chk("basic_de_count", cnt_de, 24);
    chk("basic_hs_count", cnt_hs, 16);
    chk("basic_vs_count", cnt_vs, 12);
    for (int i = 0; i < 12; i++)
      chk("pix_order", (i < rgb_q.size()) ? rgb_q[i] : 32'hdead_beef, i + 1);

    // Underflow at (2,1).
    found = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      step();
      if (x == 2 && y == 1) found = 1;
    end
    chk("uf_pos_found", found, 1);
    pix_valid = 1'b0;
    step();
    chk("uf_pixel{de,uf,rgb}", {de, underflow, rgb_out}, {1'b1, 1'b1, 32'd0});
    pix_valid = 1'b1;
    repeat (10) step();
    chk("uf_sticky", underflow, 1'b1);
    enable = 1'b0;
    found = 0;
    for (int i = 0; i < 60 && found == 0; i++) begin
      step();
      if (!underflow) found = 1;
    end
    chk("uf_clear_in_idle", found, 1);
    chk("idle_after_uf{rdy,x,y}", {pix_ready, x, y}, 64'd0);

    // Mid-frame reconfiguration: aip 4 -> 6 at y=1.
    clr_stats();
    enable = 1'b1;
    chg = 0;
    for (int i = 0; i < 120 && fs_q.size() < 3; i++) begin
      step();
      if (!chg && y == 1) begin aip_cfg = 10'd6; chg = 1; end
    end
    chk("reconf_fs_count", fs_q.size(), 3);
    chk("reconf_period_old", (fs_q.size() >= 2) ? fs_q[1] - fs_q[0] : -1, 24);
    chk("reconf_period_new", (fs_q.size() >= 3) ? fs_q[2] - fs_q[1] : -1, 32);

    // Degenerate: no blanking at all.
    enable = 1'b0;
    repeat (40) step();
    aip_cfg = 10'd4; hb_cfg = 10'd0; vb_cfg = 10'd0;
    clr_stats();
    enable = 1'b1;
    repeat (30) step();
    chk("degen_hs_count", cnt_hs, 0);
    chk("degen_vs_count", cnt_vs, 0);
    chk("degen_de_count", cnt_de, 29);

    // aip = 0 keeps the block idle.
    enable = 1'b0;
    repeat (20) step();
    aip_cfg = 10'd0;
    clr_stats();
    enable = 1'b1;
    repeat (20) step();
    chk("aip0_ready_count", cnt_rdy, 0);
    chk("aip0_fs_count", cnt_fs, 0);

    // Asynchronous reset mid-line, then restart.
    aip_cfg = 10'd4; hb_cfg = 10'd2; vb_cfg = 10'd1;
    found = 0;
    for (int i = 0; i < 30 && found == 0; i++) begin
      step();
      if (x == 3) found = 1;
    end
    chk("rst_pos_found", found, 1);
    reset = 1'b0;
    #1;
    chk("reset_async", {x, y, pix_ready, hsync, vsync, de, frame_start, underflow, rgb_out}, 64'd0);
    step(); step();
    reset = 1'b1;
    step();
    chk("restart_ready", pix_ready, 1'b1);
    chk("restart_fs_not_yet", frame_start, 1'b0);
    step();
    chk("restart_fs", frame_start, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
